// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer:
// funct3 opcodes, FSM states and operand-sign decode helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} muldiv_state_e;

  function automatic logic op_is_div(input logic [2:0] f_op);
    return f_op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] f_op);
    return (f_op == MULDIV_MULH) || (f_op == MULDIV_MULHSU) ||
           (f_op == MULDIV_DIV)  || (f_op == MULDIV_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f_op);
    return (f_op == MULDIV_MULH) || (f_op == MULDIV_DIV) || (f_op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on
// the {hi, lo} accumulator. The divide quotient bit is returned separately.
module muldiv_step import muldiv_seq_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_trial  = w_rem_sh - {1'b0, i_opnd};
    o_qbit   = 1'b0;
    o_acc    = '0;
    if (i_div) begin
      // Borrow out of the trial subtraction means restore the shifted remainder.
      o_qbit = ~w_trial[WIDTH];
      o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (IDLE/CALC/FIX/DONE).
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies and divide corner cases on accept.
module muldiv_seq import muldiv_seq_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zflag
);

  muldiv_state_e      r_state;
  logic [2:0]         r_op;
  logic               r_neg_a, r_neg_b, r_b_zero, r_ovf;
  logic               r_in_ready, r_out_valid;
  logic [WIDTH-1:0]   r_a, r_opnd, r_cnt, r_result;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_accept, w_neg_a, w_neg_b, w_b_zero, w_ovf, w_qbit;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_fix;
  logic [2*WIDTH-1:0] w_step_acc, w_prod;

  // Divide-by-zero and signed-overflow results; zero-operand multiply gives 0.
  function automatic logic [WIDTH-1:0] corner_res(input logic [2:0] f_op,
                                                  input logic [WIDTH-1:0] f_a,
                                                  input logic f_b_zero);
    if (!op_is_div(f_op)) return '0;
    if (f_b_zero) return f_op[1] ? f_a : '1;
    return f_op[1] ? '0 : f_a;
  endfunction

  assign w_accept = in_valid && r_in_ready && !kill;
  assign w_neg_a  = op_a_signed(op) & a[WIDTH-1];
  assign w_neg_b  = op_b_signed(op) & b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -a : a;
  assign w_abs_b  = w_neg_b ? -b : b;
  assign w_b_zero = (b == '0);
  assign w_ovf    = ((op == MULDIV_DIV) || (op == MULDIV_REM)) &&
                    (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);

`ifdef MULDIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = op_is_div(op) ? (w_b_zero | w_ovf) : ((a == '0) | w_b_zero);
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (op_is_div(r_op)),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (!op_is_div(r_op)) begin
      w_fix = (r_op == MULDIV_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    end else if (r_b_zero || r_ovf) begin
      w_fix = corner_res(r_op, r_a, r_b_zero);
    end else begin
      w_fix = r_op[1] ? w_rem : w_quo;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_op        <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_acc       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op       <= op;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_b_zero   <= w_b_zero;
            r_ovf      <= w_ovf;
            r_a        <= a;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            // Multiply: multiplicand |a|, multiplier |b| in lo. Divide: divisor |b|, dividend |a|.
            r_opnd     <= op_is_div(op) ? w_abs_b : w_abs_a;
            r_acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? w_abs_a : w_abs_b)};
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_result    <= corner_res(op, a, w_b_zero);
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_state <= StCalc;
            end
`else
            r_state    <= StCalc;
`endif
          end
        end
        StCalc: begin
          if (kill) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b1;
          end else begin
            r_acc <= {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_qbit};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == WIDTH'(WIDTH - 1)) r_state <= StFix;
          end
        end
        StFix: begin
          if (kill) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b1;
          end else begin
            r_result    <= w_fix;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zflag     = (r_result == '0);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M corner cases, kill, reset,
// back-to-back and random operations against a 64-bit arithmetic reference.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         in_valid = 1'b0;
  logic         kill = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zflag;
  logic [W-1:0] result;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .result    (result),
    .zflag     (zflag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc_edge;
    string        name;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the RISC-V M corner rules.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f_op,
                                             input logic [W-1:0] fa, input logic [W-1:0] fb);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(fa);
    sb = $signed(fb);
    ua = fa;
    ub = fb;
    case (f_op)
      MULDIV_MUL:    p = ua * ub;
      MULDIV_MULH:   p = (sa * sb) >> 32;
      MULDIV_MULHSU: p = (sa * longint'(ub)) >> 32;
      MULDIV_MULHU:  p = (ua * ub) >> 32;
      MULDIV_DIV: begin
        if (fb == 0) p = '1;
        else if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) p = {32'd0, fa};
        else p = sa / sb;
      end
      MULDIV_DIVU:   p = (fb == 0) ? 64'hFFFF_FFFF : ua / ub;
      MULDIV_REM: begin
        if (fb == 0) p = {32'd0, fa};
        else if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) p = '0;
        else p = sa % sb;
      end
      default:       p = (fb == 0) ? {32'd0, fa} : ua % ub;
    endcase
    return p[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f_op, input logic [W-1:0] fa,
                                 input logic [W-1:0] fb);
    logic early;
    if (f_op[2])
      early = (fb == 0) || (((f_op == MULDIV_DIV) || (f_op == MULDIV_REM)) &&
                            fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF);
    else
      early = (fa == 0) || (fb == 0);
    return (EarlyEn && early) ? 1 : W + 2;
  endfunction

  // Present a request, wait (bounded) for acceptance, push the expected response.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string nm, input bit hold, output int acc_e);
    exp_t e;
    int   waited = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    acc_e = -1;
    while (!in_ready) begin
      @(posedge clk);
      #1;
      waited++;
      if (waited > 300) begin
        checks++;
        failures++;
        $display("FAIL %s_accept_timeout in_ready=%b required=1", nm, in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc_e = edge_cnt;
    e.res = ref_model(o, x, y);
    e.lat = exp_lat(o, x, y);
    e.acc_edge = acc_e;
    e.name = nm;
    sb_q.push_back(e);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0) begin
      @(posedge clk);
      #1;
      waited++;
      if (waited > 300) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
        sb_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid result=%h required=no_pulse", result);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_zflag"}, W'(zflag), W'(e.res == '0));
        check({e.name, "_latency"}, W'(edge_cnt - e.acc_edge + 1), W'(e.lat));
      end
    end
  end

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    string        nm;
  } vec_t;

  initial begin
    vec_t dir[$];
    int   acc_e, k_e, prev_e, prev_lat;
    logic [W-1:0] saved;

    #2 rstn = 1'b0;
    #1;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_result", result, '0);
    check("reset_zflag", W'(zflag), W'(1));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    dir = '{
      '{MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, "mul_7_m3"},
      '{MULDIV_MULH,   32'h8000_0000,  32'h8000_0000, "mulh_min"},
      '{MULDIV_MULHU,  32'h8000_0000,  32'h8000_0000, "mulhu_min"},
      '{MULDIV_MULHSU, 32'hFFFF_FFFF,  32'd2,         "mulhsu_m1_2"},
      '{MULDIV_DIV,    32'hFFFF_FFEC,  32'd3,         "div_m20_3"},
      '{MULDIV_REM,    32'hFFFF_FFEC,  32'd3,         "rem_m20_3"},
      '{MULDIV_DIVU,   32'hFFFF_FFFF,  32'd16,        "divu_big_16"},
      '{MULDIV_DIV,    32'd5,          32'd0,         "div_by_zero"},
      '{MULDIV_REM,    32'd5,          32'd0,         "rem_by_zero"},
      '{MULDIV_DIVU,   32'd9,          32'd0,         "divu_by_zero"},
      '{MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf"},
      '{MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf"},
      '{MULDIV_MUL,    32'd0,          32'd12345,     "mul_zero"}
    };
    foreach (dir[i]) begin
      issue(dir[i].o, dir[i].x, dir[i].y, dir[i].nm, 1'b0, acc_e);
      drain();
    end

    // Kill mid-divide; the following MUL must be accepted on the next edge.
    issue(MULDIV_DIV, 32'd100, 32'd7, "div_killed", 1'b0, k_e);
    saved = result;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    check("kill_in_ready", W'(in_ready), W'(1));
    check("kill_result_held", result, saved);
    issue(MULDIV_MUL, 32'd6, 32'd7, "mul_after_kill", 1'b0, acc_e);
    check("kill_next_accept_edge", W'(acc_e - k_e), W'(11));
    drain();

    // Asynchronous reset mid-multiply.
    issue(MULDIV_MUL, 32'd123, 32'd456, "mul_reset", 1'b0, acc_e);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midreset_in_ready", W'(in_ready), W'(1));
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_result", result, '0);
    check("midreset_zflag", W'(zflag), W'(1));
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Back-to-back with in_valid held: accepts spaced by latency + 1.
    dir = '{
      '{MULDIV_MUL,   32'd1000,      32'd3,         "b2b_mul"},
      '{MULDIV_DIVU,  32'hDEAD_BEEF, 32'd77,        "b2b_divu"},
      '{MULDIV_REM,   32'h8000_0001, 32'd10,        "b2b_rem"},
      '{MULDIV_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_mulhu"}
    };
    prev_e = -1;
    prev_lat = 0;
    foreach (dir[i]) begin
      issue(dir[i].o, dir[i].x, dir[i].y, dir[i].nm, (i != 3), acc_e);
      if (prev_e >= 0) check({dir[i].nm, "_spacing"}, W'(acc_e - prev_e), W'(prev_lat + 1));
      prev_e = acc_e;
      prev_lat = exp_lat(dir[i].o, dir[i].x, dir[i].y);
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      issue(ro, rnd_opnd(), rnd_opnd(), $sformatf("rand%0d_op%0d", i, ro),
            (i != 39) && ($urandom_range(0, 1) == 1), acc_e);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
